// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - ARM-subset execute stage: shifter, ALU, branch target, NZCV and EX/MEM register.
// Optional operand forwarding muxes are enabled by defining FORWARDING_EN.
module exe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              wb_enable_in,
  input  logic              mem_read_enable_in,
  input  logic              mem_write_enable_in,
  input  logic              branch_enable_in,
  input  logic              S_in,
  input  logic [3:0]        exec_cmd_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic              immidiate_in,
  input  logic [11:0]       Shift_operand_in,
  input  logic [23:0]       Signed_immidiate_24_in,
  input  logic [REG_AW-1:0] Dest_in,
  input  logic [3:0]        Status_in,
`ifdef FORWARDING_EN
  input  logic [1:0]        sel_src1,
  input  logic [1:0]        sel_src2,
  input  logic [DATA_W-1:0] mem_fwd_val,
  input  logic [DATA_W-1:0] wb_fwd_val,
`endif
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_addr,
  output logic [3:0]        status,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] st_val,
  output logic [REG_AW-1:0] dest,
  output logic              wb_enable,
  output logic              mem_read_enable,
  output logic              mem_write_enable
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [DATA_W-1:0] op1, rm_val, val2, alu_out;
  logic [DATA_W:0]   sum;
  logic [4:0]        sh_amt;
  logic              carry_in, n_f, z_f, c_f, v_f;
  logic [3:0]        nzcv;

  function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input logic [4:0] r);
    return (x >> r) | (x << (6'd32 - {1'b0, r}));
  endfunction

`ifdef FORWARDING_EN
  always_comb begin
    case (sel_src1)
      2'b01:   op1 = mem_fwd_val;
      2'b10:   op1 = wb_fwd_val;
      default: op1 = Val_Rn_in;
    endcase
    case (sel_src2)
      2'b01:   rm_val = mem_fwd_val;
      2'b10:   rm_val = wb_fwd_val;
      default: rm_val = Val_Rm_in;
    endcase
  end
`else
  assign op1    = Val_Rn_in;
  assign rm_val = Val_Rm_in;
`endif

  assign sh_amt = Shift_operand_in[11:7];

  // Memory ops take the raw 12-bit offset; only register operands go through the barrel shifter.
  always_comb begin
    val2 = rm_val;
    if (immidiate_in)
      val2 = ror({{(DATA_W-8){1'b0}}, Shift_operand_in[7:0]}, {Shift_operand_in[11:8], 1'b0});
    else if (mem_read_enable_in || mem_write_enable_in)
      val2 = {{(DATA_W-12){1'b0}}, Shift_operand_in};
    else if (sh_amt != 5'd0) begin
      case (Shift_operand_in[6:5])
        2'b00:   val2 = rm_val << sh_amt;
        2'b01:   val2 = rm_val >> sh_amt;
        2'b10:   val2 = $signed(rm_val) >>> sh_amt;
        default: val2 = ror(rm_val, sh_amt);
      endcase
    end
  end

  assign carry_in = Status_in[1];

  always_comb begin
    sum     = '0;
    alu_out = '0;
    c_f     = Status_in[1];
    v_f     = Status_in[0];
    case (exec_cmd_in)
      CMD_MOV: alu_out = val2;
      CMD_MVN: alu_out = ~val2;
      CMD_AND: alu_out = op1 & val2;
      CMD_ORR: alu_out = op1 | val2;
      CMD_EOR: alu_out = op1 ^ val2;
      CMD_ADD, CMD_ADC: begin
        sum     = {1'b0, op1} + {1'b0, val2}
                + {{DATA_W{1'b0}}, (exec_cmd_in == CMD_ADC) & carry_in};
        alu_out = sum[DATA_W-1:0];
        c_f     = sum[DATA_W];
        v_f     = (op1[DATA_W-1] == val2[DATA_W-1]) && (alu_out[DATA_W-1] != op1[DATA_W-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // Carry out is NOT borrow: bit 32 of the 33-bit difference flags a borrow.
        sum     = {1'b0, op1} - {1'b0, val2}
                - {{DATA_W{1'b0}}, (exec_cmd_in == CMD_SBC) & ~carry_in};
        alu_out = sum[DATA_W-1:0];
        c_f     = ~sum[DATA_W];
        v_f     = (op1[DATA_W-1] != val2[DATA_W-1]) && (alu_out[DATA_W-1] != op1[DATA_W-1]);
      end
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    n_f  = alu_out[DATA_W-1];
    z_f  = (alu_out == '0);
    nzcv = {n_f, z_f, c_f, v_f};
    case (exec_cmd_in)
      CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
      CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: nzcv = {n_f, z_f, c_f, v_f};
      default:                            nzcv = Status_in;
    endcase
  end

  assign branch_taken = branch_enable_in;
  assign branch_addr  = PC_in + {{(DATA_W-26){Signed_immidiate_24_in[23]}}, Signed_immidiate_24_in, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      status           <= '0;
      alu_res          <= '0;
      st_val           <= '0;
      dest             <= '0;
      wb_enable        <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
    end else if (!freeze) begin
      alu_res          <= alu_out;
      st_val           <= rm_val;
      dest             <= Dest_in;
      wb_enable        <= wb_enable_in;
      mem_read_enable  <= mem_read_enable_in;
      mem_write_enable <= mem_write_enable_in;
      if (S_in)
        status <= nzcv;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - randomized self-checking bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst, freeze;
  logic        wb_enable_in, mem_read_enable_in, mem_write_enable_in, branch_enable_in, S_in;
  logic [3:0]  exec_cmd_in;
  logic [31:0] PC_in, Val_Rn_in, Val_Rm_in;
  logic        immidiate_in;
  logic [11:0] Shift_operand_in;
  logic [23:0] Signed_immidiate_24_in;
  logic [3:0]  Dest_in, Status_in;
`ifdef FORWARDING_EN
  logic [1:0]  sel_src1, sel_src2;
  logic [31:0] mem_fwd_val, wb_fwd_val;
`endif
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  status;
  logic [31:0] alu_res, st_val;
  logic [3:0]  dest;
  logic        wb_enable, mem_read_enable, mem_write_enable;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] e_alu, e_st;
  logic [3:0]  e_dest, e_status;
  logic [2:0]  e_ctl;

  exe_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_enable_in(wb_enable_in), .mem_read_enable_in(mem_read_enable_in),
    .mem_write_enable_in(mem_write_enable_in), .branch_enable_in(branch_enable_in),
    .S_in(S_in), .exec_cmd_in(exec_cmd_in), .PC_in(PC_in),
    .Val_Rn_in(Val_Rn_in), .Val_Rm_in(Val_Rm_in), .immidiate_in(immidiate_in),
    .Shift_operand_in(Shift_operand_in), .Signed_immidiate_24_in(Signed_immidiate_24_in),
    .Dest_in(Dest_in), .Status_in(Status_in),
`ifdef FORWARDING_EN
    .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
`endif
    .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
    .alu_res(alu_res), .st_val(st_val), .dest(dest), .wb_enable(wb_enable),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
    return (n == 0) ? x : ((x >> n) | (x << (32 - n)));
  endfunction

  function automatic logic [31:0] m_val2(input logic [31:0] rm);
    int n;
    if (immidiate_in) return m_ror({24'd0, Shift_operand_in[7:0]}, 2 * int'(Shift_operand_in[11:8]));
    if (mem_read_enable_in || mem_write_enable_in) return {20'd0, Shift_operand_in};
    n = int'(Shift_operand_in[11:7]);
    if (n == 0) return rm;
    case (Shift_operand_in[6:5])
      2'b00:   return rm << n;
      2'b01:   return rm >> n;
      2'b10:   return $signed(rm) >>> n;
      default: return m_ror(rm, n);
    endcase
  endfunction

  function automatic logic [31:0] m_op1();
`ifdef FORWARDING_EN
    if (sel_src1 == 2'b01) return mem_fwd_val;
    if (sel_src1 == 2'b10) return wb_fwd_val;
`endif
    return Val_Rn_in;
  endfunction

  function automatic logic [31:0] m_rm();
`ifdef FORWARDING_EN
    if (sel_src2 == 2'b01) return mem_fwd_val;
    if (sel_src2 == 2'b10) return wb_fwd_val;
`endif
    return Val_Rm_in;
  endfunction

  // Reference ALU using wide integer arithmetic for carry and signed overflow.
  task automatic m_alu(output logic [31:0] res, output logic [3:0] nzcv);
    logic [31:0] a, b;
    longint ua, ub, sa, sb, full, sfull;
    logic c, v, arith;
    a = m_op1(); b = m_val2(m_rm());
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    c = Status_in[1]; v = Status_in[0]; arith = 1'b0; full = 0; sfull = 0;
    case (exec_cmd_in)
      4'b0001: res = b;
      4'b1001: res = ~b;
      4'b0110: res = a & b;
      4'b0111: res = a | b;
      4'b1000: res = a ^ b;
      4'b0010: begin full = ua + ub; sfull = sa + sb; arith = 1'b1; end
      4'b0011: begin full = ua + ub + longint'(Status_in[1]); sfull = sa + sb + longint'(Status_in[1]); arith = 1'b1; end
      4'b0100: begin full = ua - ub; sfull = sa - sb; arith = 1'b1; end
      4'b0101: begin full = ua - ub - longint'(!Status_in[1]); sfull = sa - sb - longint'(!Status_in[1]); arith = 1'b1; end
      default: res = 32'd0;
    endcase
    if (arith) begin
      res = full[31:0];
      c = (exec_cmd_in[2]) ? (full >= 0) : (full > 64'sd4294967295);
      v = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
    end
    case (exec_cmd_in)
      4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000:
        nzcv = {res[31], res == 32'd0, c, v};
      default: nzcv = Status_in;
    endcase
  endtask

  // Apply the currently driven inputs for one clock, checking branch outputs before the edge.
  task automatic step(input string tag);
    logic [31:0] res, tgt;
    logic [3:0]  nzcv;
    #1;
    tgt = PC_in + (32'(signed'(Signed_immidiate_24_in)) * 4);
    check({tag, ".br_taken"}, {31'd0, branch_taken}, {31'd0, branch_enable_in});
    check({tag, ".br_addr"}, branch_addr, tgt);
    m_alu(res, nzcv);
    if (rst) begin
      e_alu = 0; e_st = 0; e_dest = 0; e_ctl = 0; e_status = 0;
    end else if (!freeze) begin
      e_alu = res; e_st = m_rm(); e_dest = Dest_in;
      e_ctl = {wb_enable_in, mem_read_enable_in, mem_write_enable_in};
      if (S_in) e_status = nzcv;
    end
    @(posedge clk); #1;
    check({tag, ".alu_res"}, alu_res, e_alu);
    check({tag, ".st_val"}, st_val, e_st);
    check({tag, ".dest"}, {28'd0, dest}, {28'd0, e_dest});
    check({tag, ".ctl"}, {29'd0, wb_enable, mem_read_enable, mem_write_enable}, {29'd0, e_ctl});
    check({tag, ".status"}, {28'd0, status}, {28'd0, e_status});
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; freeze = 0; wb_enable_in = 0; mem_read_enable_in = 0; mem_write_enable_in = 0;
    branch_enable_in = 0; S_in = 0; exec_cmd_in = 0; PC_in = 0; Val_Rn_in = 0; Val_Rm_in = 0;
    immidiate_in = 0; Shift_operand_in = 0; Signed_immidiate_24_in = 0; Dest_in = 0; Status_in = 0;
`ifdef FORWARDING_EN
    sel_src1 = 0; sel_src2 = 0; mem_fwd_val = 0; wb_fwd_val = 0;
`endif
  endtask

  task automatic alu_op(input logic [3:0] cmd, input logic [31:0] rn, rm, input logic imm,
                        input logic [11:0] so, input logic s);
    idle();
    exec_cmd_in = cmd; Val_Rn_in = rn; Val_Rm_in = rm; immidiate_in = imm;
    Shift_operand_in = so; S_in = s; wb_enable_in = 1; Dest_in = 4'd3;
  endtask

  initial begin
    idle();
    rst = 1;
    Val_Rn_in = 32'h1234; S_in = 1; exec_cmd_in = 4'b0010; wb_enable_in = 1;
    @(negedge clk);
    step("reset");

    alu_op(4'b0010, 32'd5, 32'd7, 0, 12'h000, 1);  step("add");
    check("add.val", alu_res, 32'd12);
    check("add.nzcv", {28'd0, status}, 32'd0);
    alu_op(4'b0100, 32'd3, 32'd5, 0, 12'h000, 1);  step("sub_neg");
    check("sub_neg.val", alu_res, 32'hFFFF_FFFE);
    check("sub_neg.nzcv", {28'd0, status}, 32'h8);
    alu_op(4'b0100, 32'h8000_0000, 32'd1, 0, 12'h000, 1); step("sub_ovf");
    check("sub_ovf.nzcv", {28'd0, status}, 32'h3);
    alu_op(4'b0001, 32'd0, 32'd0, 1, 12'h4FF, 0); step("mov_imm");
    check("mov_imm.val", alu_res, 32'hFF00_0000);
    alu_op(4'b0001, 32'd0, 32'h8000_0000, 0, 12'h240, 0); step("mov_asr");
    check("mov_asr.val", alu_res, 32'hF800_0000);

    idle(); branch_enable_in = 1; PC_in = 32'h100; Signed_immidiate_24_in = 24'hFFFFFE;
    #1; check("branch.addr", branch_addr, 32'h0000_00F8);
    check("branch.taken", {31'd0, branch_taken}, 32'd1);
    step("branch");

    alu_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 0, 12'h000, 1); step("pre_freeze");
    for (int i = 0; i < 2; i++) begin
      alu_op(4'b0111, $urandom, $urandom, 0, 12'h000, 1); freeze = 1; Dest_in = 4'd9;
      step("freeze");
    end
    check("freeze.held", alu_res, 32'd0);
    alu_op(4'b0001, 32'd0, 32'd0, 1, 12'h0FF, 0); step("unfreeze");
    alu_op(4'b0010, 32'd1, 32'd1, 0, 12'h000, 1); rst = 1; freeze = 1; step("rst_freeze");

`ifdef FORWARDING_EN
    alu_op(4'b0010, 32'd99, 32'd1, 0, 12'h000, 0); sel_src1 = 2'b01; mem_fwd_val = 32'd10;
    step("fwd_add");
    check("fwd_add.val", alu_res, 32'd11);
    alu_op(4'b0010, 32'd4, 32'd5, 0, 12'h008, 0); mem_write_enable_in = 1; wb_enable_in = 0;
    sel_src2 = 2'b10; wb_fwd_val = 32'hCAFE_F00D; step("fwd_str");
    check("fwd_str.st_val", st_val, 32'hCAFE_F00D);
`endif

    for (int i = 0; i < 400; i++) begin
      idle();
      if ($urandom_range(0, 9) != 0) begin
        exec_cmd_in = 4'($urandom);
        Val_Rn_in = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 - 32'($urandom_range(0, 2)) : $urandom;
        Val_Rm_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
        immidiate_in = 1'($urandom); Shift_operand_in = 12'($urandom);
        S_in = 1'($urandom); wb_enable_in = 1'($urandom);
        mem_read_enable_in = ($urandom_range(0, 3) == 0);
        mem_write_enable_in = !mem_read_enable_in && ($urandom_range(0, 3) == 0);
        branch_enable_in = ($urandom_range(0, 5) == 0);
        PC_in = $urandom; Signed_immidiate_24_in = 24'($urandom);
        Dest_in = 4'($urandom); Status_in = 4'($urandom);
        freeze = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 49) == 0);
`ifdef FORWARDING_EN
        sel_src1 = 2'($urandom); sel_src2 = 2'($urandom);
        mem_fwd_val = $urandom; wb_fwd_val = $urandom;
`endif
      end
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
